data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Data-memory stage directly downstream of the MIPS core's M-stage memory port.
- Consumes m_data_addr / m_data_wdata / m_data_byteen / m_inst_addr and returns m_data_rdata.
- Holds a byte-enabled word memory with combinational read and clocked write.
- Pushes every effective store into a trace FIFO drained by a valid/ready consumer (testbench logger or debug bus).

Parameters:
- ADDR_WIDTH, 12, byte-address width of memory; depth = 2^(ADDR_WIDTH-2) words.
- FIFO_DEPTH, 8, trace FIFO entries; power of two, >= 2.
- CNT_WIDTH, 8, width of the saturating dropped-store counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_data_addr  in  32  byte address from core.
- m_data_wdata  in  32  store data, already lane-aligned by core.
- m_data_byteen  in  4  byte write enables; 4'b0000 = no store.
- m_inst_addr  in  32  PC of the M-stage instruction, for trace.
- m_data_rdata  out  32  read data, combinational.
- addr_err  out  1  combinational: addr[31:ADDR_WIDTH] != 0.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer accepts head entry this cycle.
- trace_pc  out  32  head entry PC.
- trace_addr  out  32  head entry word-aligned address ({addr[31:2],2'b00}).
- trace_data  out  32  head entry merged word after the store.
- trace_byteen  out  4  head entry byte enables.
- drop_cnt  out  CNT_WIDTH  stores lost to FIFO overflow; saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - All memory words = 0; FIFO empty (trace_valid=0); drop_cnt = 0.
  - trace_* data outputs = 0 while empty.
  - Any store in flight is discarded.
- Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored for indexing.
- Read path:
  - m_data_rdata = mem[index] when addr_err=0, else 32'h0.
  - Purely combinational, zero latency.
  - Reflects pre-edge contents; a same-cycle store is not forwarded.
- Store accepted when byteen != 0 and addr_err = 0. At the rising edge, merged word: byte i = byteen[i] ? wdata[8i+7:8i] : old byte i.
  - mem[index] <= merged.
  - Trace entry {pc, aligned addr, merged, byteen} pushed to FIFO.
- Store with addr_err=1: memory unchanged, no trace push, no drop_cnt change.
- FIFO:
  - Read and write pointers carry one extra wrap bit.
  - Full = same index, wrap bits differ; empty = pointers equal.
  - Pop occurs when trace_valid & trace_ready.
  - Head outputs show the oldest entry, registered storage, no added latency.
- Simultaneous push and pop:
  - Not full: both occur; count unchanged.
  - Full: pop frees a slot and the push is accepted; no drop.
  - Empty: push only; entry visible next cycle (no bypass); trace_ready ignored while empty.
- Overflow (push while full without pop): entry discarded; drop_cnt += 1, saturating at 2^CNT_WIDTH-1; FIFO contents untouched.
- Pointer wrap: index wraps modulo FIFO_DEPTH and the wrap bit toggles; order is preserved across wrap.
- No stalls toward the core: memory writes always complete, regardless of FIFO state.

Test Plan:
- Reset then read addr 0x0000_0010 -> m_data_rdata=0, trace_valid=0, drop_cnt=0.
- Store wdata=0x1122_3344, byteen=4'hF, addr=0x10, pc=0x3000; then byteen=4'h2, wdata=0x0000_AA00 to addr 0x11 -> read 0x10 returns 0x1122_AA44; FIFO holds two entries, second trace_addr=0x10, trace_data=0x1122_AA44, trace_byteen=4'h2.
- trace_ready=0, issue 10 stores to distinct addresses -> first 8 queued, drop_cnt=2; then drain with trace_ready=1 -> 8 entries in order, trace_valid falls after the 8th pop.
- FIFO full with simultaneous store and trace_ready=1 -> count stays 8, drop_cnt unchanged, new entry appears last; repeat >16 cycles to exercise pointer wrap with order intact.
- Store to addr 0x0000_1000 (addr_err=1) -> memory unchanged, no push, read returns 0, addr_err=1.
- Assert reset low mid-burst with FIFO half full -> memory cleared, trace_valid=0, drop_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Generic FIFO with wrap-bit pointers, used for the store trace queue.
// Latency: entry visible on pop side one cycle after push (no bypass).
// Backpressure: push_rdy drops when full unless a pop frees a slot in the same cycle.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign pop_vld  = !empty;
    assign do_pop   = pop_vld && pop_rdy;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push_rdy = !full || pop_rdy;
    assign do_push  = push_vld && push_rdy;
    assign pop_dat  = store[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= push_dat;
    end
endmodule

// Data-memory stage: byte-enabled word memory plus a trace queue of every effective store.
// Latency: reads combinational (pre-edge contents), writes and trace pushes on the rising edge.
// Backpressure: never stalls the core; stores arriving at a full trace queue are counted and dropped.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          m_data_addr,
    input  logic [31:0]          m_data_wdata,
    input  logic [3:0]           m_data_byteen,
    input  logic [31:0]          m_inst_addr,
    output logic [31:0]          m_data_rdata,
    output logic                 addr_err,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [31:0]          trace_pc,
    output logic [31:0]          trace_addr,
    output logic [31:0]          trace_data,
    output logic [3:0]           trace_byteen,
    output logic [CNT_WIDTH-1:0] drop_cnt
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int WORDS = 1 << IW;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } trace_t;

    logic [31:0] mem [WORDS];
    logic [IW-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic        store_acc;
    logic        push_rdy;
    logic        overflow;
    trace_t      push_dat;
    trace_t      head;
    logic        unused_addr_lsb;

    assign idx             = m_data_addr[ADDR_WIDTH-1:2];
    assign unused_addr_lsb = ^m_data_addr[1:0];
    assign addr_err        = |m_data_addr[31:ADDR_WIDTH];
    assign rd_word         = mem[idx];
    assign m_data_rdata    = addr_err ? 32'h0 : rd_word;
    assign store_acc       = (m_data_byteen != 4'b0000) && !addr_err;

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (store_acc) begin
            mem[idx] <= merged;
        end
    end

    always_comb begin
        push_dat.pc     = m_inst_addr;
        push_dat.addr   = {m_data_addr[31:2], 2'b00};
        push_dat.data   = merged;
        push_dat.byteen = m_data_byteen;
    end

    fifo #(
        .WIDTH ($bits(trace_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk      (clk),
        .arst_n   (reset),
        .push_vld (store_acc),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (trace_valid),
        .pop_rdy  (trace_ready),
        .pop_dat  (head)
    );

    // Head fields read as zero while empty so stale storage never leaks out.
    assign trace_pc     = trace_valid ? head.pc     : 32'h0;
    assign trace_addr   = trace_valid ? head.addr   : 32'h0;
    assign trace_data   = trace_valid ? head.data   : 32'h0;
    assign trace_byteen = trace_valid ? head.byteen : 4'h0;

    assign overflow = store_acc && !push_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (overflow && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Random and directed stimulus against a byte-array memory model and a trace scoreboard queue.
module tb_data_mem_ctrl;
    localparam int AW = 12;
    localparam int FD = 8;
    localparam int CW = 8;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   m_data_addr;
    logic [31:0]   m_data_wdata;
    logic [3:0]    m_data_byteen;
    logic [31:0]   m_inst_addr;
    logic [31:0]   m_data_rdata;
    logic          addr_err;
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [31:0]   trace_addr;
    logic [31:0]   trace_data;
    logic [3:0]    trace_byteen;
    logic [CW-1:0] drop_cnt;

    data_mem_ctrl #(.ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .addr_err      (addr_err),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_pc      (trace_pc),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_byteen  (trace_byteen),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t       exp_q[$];
    ent_t       pend;
    bit         pend_push;
    bit         pend_drop;
    bit         pend_wr;
    logic [7:0] bmem [1 << AW];
    int         drop_m;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a[AW-1:0]) & ~3;
        return {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < (1 << AW); i++) bmem[i] = 8'h00;
        exp_q.delete();
        pend_push = 0;
        pend_drop = 0;
        pend_wr   = 0;
        drop_m    = 0;
    endtask

    // Scoreboard monitor: compares the presented head and retires it on handshake.
    always @(negedge clk) begin
        if (reset) begin
            chk("trace_valid", {31'b0, trace_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("trace_pc", trace_pc, exp_q[0].pc);
                chk("trace_addr", trace_addr, exp_q[0].addr);
                chk("trace_data", trace_data, exp_q[0].data);
                chk("trace_byteen", {28'b0, trace_byteen}, {28'b0, exp_q[0].be});
                if (trace_ready) void'(exp_q.pop_front());
            end else begin
                chk("trace_data_idle", trace_data, 32'h0);
                chk("trace_pc_idle", trace_pc, 32'h0);
            end
        end
    end

    // One core cycle: retire last cycle's model effects at the edge, drive, check reads, predict.
    task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] pc, input bit rdy);
        logic [31:0] merged;
        bit          err;
        int          base;
        @(posedge clk);
        if (pend_wr) begin
            base = int'(pend.addr[AW-1:0]);
            for (int i = 0; i < 4; i++) bmem[base+i] = pend.data[8*i +: 8];
        end
        if (pend_push) exp_q.push_back(pend);
        if (pend_drop && drop_m < DROP_MAX) drop_m++;
        pend_wr = 0; pend_push = 0; pend_drop = 0;
        #1;
        m_data_addr = a; m_data_wdata = wd; m_data_byteen = be; m_inst_addr = pc; trace_ready = rdy;
        #1;
        err = (a >> AW) != 0;
        chk("addr_err", {31'b0, addr_err}, {31'b0, err});
        chk("rdata", m_data_rdata, err ? 32'h0 : model_word(a));
        chk("drop_cnt", {24'b0, drop_cnt}, drop_m);
        if (be != 4'b0000 && !err) begin
            merged = model_word(a);
            for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
            pend.pc = pc; pend.addr = a & 32'hFFFF_FFFC; pend.data = merged; pend.be = be;
            pend_wr = 1;
            if (exp_q.size() < FD || (rdy && exp_q.size() > 0)) pend_push = 1;
            else pend_drop = 1;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(32'h10, 32'h0, 4'h0, 32'h0, rdy);
    endtask

    initial begin
        reset = 1'b0;
        m_data_addr = 0; m_data_wdata = 0; m_data_byteen = 0; m_inst_addr = 0; trace_ready = 0;
        model_clear();
        #12 reset = 1'b1;

        // Reset state
        cycle(32'h10, 32'h0, 4'h0, 32'h0, 0);
        chk("reset_rdata", m_data_rdata, 32'h0);
        chk("reset_valid", {31'b0, trace_valid}, 32'h0);
        chk("reset_drop", {24'b0, drop_cnt}, 32'h0);

        // Full-word store followed by a single-lane merge
        cycle(32'h10, 32'h1122_3344, 4'hF, 32'h3000, 0);
        cycle(32'h11, 32'h0000_AA00, 4'h2, 32'h3004, 0);
        cycle(32'h10, 32'h0, 4'h0, 32'h0, 0);
        chk("merge_rdata", m_data_rdata, 32'h1122_AA44);
        idle(3, 1);

        // Overflow: ten stores into an 8-entry queue
        for (int i = 0; i < 10; i++) cycle(32'h100 + 4*i, $urandom, 4'hF, 32'h4000 + 4*i, 0);
        idle(1, 0);
        chk("overflow_drop", {24'b0, drop_cnt}, 32'd2);
        idle(9, 1);
        chk("drained_valid", {31'b0, trace_valid}, 32'h0);

        // Full queue with simultaneous push/pop, long enough to wrap the pointers
        for (int i = 0; i < 8; i++) cycle(32'h200 + 4*i, $urandom, 4'hF, 32'h5000 + 4*i, 0);
        for (int i = 0; i < 20; i++) cycle(32'h300 + 4*i, $urandom, 4'hF, 32'h6000 + 4*i, 1);
        idle(1, 0);
        chk("full_pushpop_drop", {24'b0, drop_cnt}, 32'd2);
        idle(9, 1);

        // Out-of-range store
        cycle(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h7000, 0);
        chk("err_flag", {31'b0, addr_err}, 32'h1);
        chk("err_rdata", m_data_rdata, 32'h0);
        idle(2, 0);
        chk("err_no_push", {31'b0, trace_valid}, 32'h0);

        // Counter saturation
        for (int i = 0; i < 300; i++) cycle($urandom_range(0, (1 << AW) - 1), $urandom, 4'hF, 32'h8000 + i, 0);
        idle(1, 0);
        chk("drop_saturate", {24'b0, drop_cnt}, DROP_MAX);
        idle(9, 1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, (1 << AW) - 1);
            cycle(a, $urandom, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
        end
        idle(10, 1);

        // Asynchronous reset mid-burst with the queue half full
        for (int i = 0; i < 4; i++) cycle(32'h10 + 4*i, 32'hA5A5_0000 + i, 4'hF, 32'h9000 + 4*i, 0);
        cycle(32'h10, 32'h0, 4'h0, 32'h0, 0);
        chk("pre_reset_valid", {31'b0, trace_valid}, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("async_valid", {31'b0, trace_valid}, 32'h0);
        chk("async_drop", {24'b0, drop_cnt}, 32'h0);
        chk("async_rdata", m_data_rdata, 32'h0);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
        idle(3, 1);
        cycle(32'h14, 32'h0, 4'h0, 32'h0, 1);
        chk("post_reset_rdata", m_data_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
